axis_packet_arbiter: RTL and testbench
======================================

// Module: axis_packet_arbiter
// PURPOSE
// Single-clock, packet-aware N:1 AXI-Stream arbiter for merging FMPS/CC packet streams ahead of AXIS2Packet.
// Grants one source per packet (lock until TLAST), selectable round-robin or fixed priority, per-source enable mask,
// source index tagged on m_tid. A per-packet watchdog terminates stalled packets with an error-flagged TLAST beat.
// Registered output stage; sits after per-link CDC FIFOs, in the system clock domain.
// PARAMETERS
// NUM_SOURCES     4     number of slave streams (>=1)
// DATA_WIDTH      32    TDATA width
// USER_WIDTH      1     TUSER width, passed through unchanged
// ID_WIDTH        $clog2(NUM_SOURCES), min 1   width of m_tid
// TIMEOUT_CYCLES  1024  idle cycles allowed mid-packet before forced termination; 0 disables watchdog
// PORTS
// clk            in   1                       single clock, all logic rising-edge
// arst_n         in   1                       asynchronous, active-low reset
// mode           in   1                       0 = round-robin, 1 = fixed priority (lowest index wins)
// enable         in   NUM_SOURCES             per-source grant enable mask
// s_tvalid       in   NUM_SOURCES             slave TVALID, bit i = source i
// s_tready       out  NUM_SOURCES             slave TREADY
// s_tlast        in   NUM_SOURCES             slave TLAST
// s_tdata        in   DATA_WIDTH*NUM_SOURCES  slave TDATA, source i at [(i+1)*DATA_WIDTH-1:i*DATA_WIDTH]
// s_tuser        in   USER_WIDTH*NUM_SOURCES  slave TUSER, same packing
// m_tvalid       out  1                       master TVALID
// m_tready       in   1                       master TREADY
// m_tlast        out  1                       master TLAST
// m_tdata        out  DATA_WIDTH              master TDATA
// m_tuser        out  USER_WIDTH              master TUSER
// m_tid          out  ID_WIDTH                index of source owning current beat
// m_terr         out  1                       1 on watchdog terminator beat only
// timeoutStrobe  out  1                       1-cycle pulse when watchdog fires
// grantIdx       out  ID_WIDTH                currently/last granted source (status)
// BEHAVIOUR
// - Reset (async assert, sync release): all outputs 0; state IDLE; RR pointer = NUM_SOURCES-1 so source 0 wins first.
//   Reset mid-packet drops the beat in the output register and the partial packet; no recovery beat is emitted.
// - Output register "free" = !m_tvalid || m_tready. m_* are held stable while m_tvalid && !m_tready.
// - FSM IDLE: req = s_tvalid & enable. If req != 0, pick winner, register grantIdx, go PASS.
//   RR picks the first set req bit after last grant, wrapping. PRI picks the lowest set bit. s_tready = 0 in IDLE.
// - PASS: s_tready[grantIdx] = free; all other s_tready = 0. On s_tvalid&&s_tready, load output register
//   with the source's data/user/last, m_tid = grantIdx, m_terr = 0, and set m_tvalid.
//   On the TLAST beat, update the RR pointer to grantIdx and go IDLE.
// - Latency: s_tvalid seen in IDLE at cycle N -> s_tready high at N+1 -> m_tvalid at N+2. Max throughput in PASS is 1 beat/cycle.
//   One IDLE cycle is spent between packets.
// - enable/mode changes take effect only at the next IDLE arbitration; the packet in flight is never cut.
// - Watchdog (TIMEOUT_CYCLES>0): counter cleared on entering PASS and on every accepted beat.
//   Increments only in PASS when s_tvalid[grantIdx]==0; does not count while downstream stalls.
//   Saturates at TIMEOUT_CYCLES. When it is saturated and the output register is free:
//   load a terminator beat (tdata=0, tuser=0, tlast=1, terr=1, tid=grantIdx), pulse timeoutStrobe,
//   and go FLUSH. s_tready[grantIdx] = 0 on that cycle.
// - FLUSH: s_tready[grantIdx] = 1, accepted beats are discarded (no m_* activity). On the discarded TLAST beat,
//   update the RR pointer and go IDLE. Enable mask ignored in FLUSH.
// - A source beat arriving on the same cycle the counter saturates wins: the beat is accepted, counter cleared, no timeout.
// - NUM_SOURCES=1: arbitration is trivial; mode is ignored; m_tid=0.
// TESTING
// 1. RR: mode=0, enable=4'hF, all 4 sources always valid, 2-beat packets, m_tready=1 -> m_tid per packet 0,1,2,3,0,...;
//    no interleave within a packet.
// 2. PRI: mode=1, sources 0 and 2 always valid -> only tid 0; clear enable[0] mid-packet -> packet completes,
//    then tid 2 only.
// 3. Backpressure: m_tready random 50%, 4 sources, counting-pattern data -> per-source data in order,
//    no loss/duplication, m_* stable while stalled.
// 4. Timeout: TIMEOUT_CYCLES=16, source 1 sends 1 beat (no TLAST) then idles 16 cycles ->
//    terminator {tdata=0,tlast=1,terr=1,tid=1} and a timeoutStrobe pulse. Then 3 more source-1 beats ending TLAST
//    are accepted and nothing appears on m_*; the next grant goes to source 2.
// 5. Reset mid-packet: arst_n=0 during PASS with m_tvalid=1 -> m_tvalid, s_tready = 0 immediately;
//    after release with all valid, first m_tid = 0.
// 6. Latency: idle bus, 1-beat packet on source 3 at cycle N -> s_tready[3]=1 at N+1, m_tvalid=1 with tlast=1, tid=3 at N+2.

Source files
------------

// File: rtl/axis_packet_arbiter.sv
`default_nettype none
// ============================================================================
// axis_packet_arbiter : packet-locked N:1 AXI-Stream arbiter (RR / fixed prio)
// with mid-packet watchdog and registered output stage.       Rev 1.0
// ============================================================================
module axis_packet_arbiter #(
    parameter int NUM_SOURCES    = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int USER_WIDTH     = 1,
    parameter int ID_WIDTH       = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic                              mode,
    input  logic [NUM_SOURCES-1:0]            enable,
    input  logic [NUM_SOURCES-1:0]            s_tvalid,
    output logic [NUM_SOURCES-1:0]            s_tready,
    input  logic [NUM_SOURCES-1:0]            s_tlast,
    input  logic [DATA_WIDTH*NUM_SOURCES-1:0] s_tdata,
    input  logic [USER_WIDTH*NUM_SOURCES-1:0] s_tuser,
    output logic                              m_tvalid,
    input  logic                              m_tready,
    output logic                              m_tlast,
    output logic [DATA_WIDTH-1:0]             m_tdata,
    output logic [USER_WIDTH-1:0]             m_tuser,
    output logic [ID_WIDTH-1:0]               m_tid,
    output logic                              m_terr,
    output logic                              timeoutStrobe,
    output logic [ID_WIDTH-1:0]               grantIdx
);

    localparam int                    CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic                  WD_ENABLE = (TIMEOUT_CYCLES > 0);
    localparam logic [ID_WIDTH-1:0]   LAST_SRC  = ID_WIDTH'(NUM_SOURCES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [ID_WIDTH-1:0]     rr_ptr;
    logic [ID_WIDTH-1:0]     winner;
    logic [CNT_WIDTH-1:0]    wd_cnt;
    logic [NUM_SOURCES-1:0]  req;
    logic                    out_free;
    logic                    src_valid;
    logic                    src_last;
    logic [DATA_WIDTH-1:0]   src_data;
    logic [USER_WIDTH-1:0]   src_user;
    logic                    accept;
    logic                    fire;

    assign out_free  = !m_tvalid || m_tready;
    assign req       = s_tvalid & enable;
    assign src_valid = s_tvalid[grantIdx];
    assign src_last  = s_tlast[grantIdx];
    assign src_data  = s_tdata[int'(grantIdx) * DATA_WIDTH +: DATA_WIDTH];
    assign src_user  = s_tuser[int'(grantIdx) * USER_WIDTH +: USER_WIDTH];

    // Descending scan: the last hit written is the closest one to the start point.
    always_comb begin
        winner = '0;
        if (mode || (NUM_SOURCES == 1)) begin
            for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
                if (req[i]) winner = ID_WIDTH'(i);
            end
        end else begin
            for (int i = NUM_SOURCES; i >= 1; i--) begin
                if (req[(int'(rr_ptr) + i) % NUM_SOURCES])
                    winner = ID_WIDTH'((int'(rr_ptr) + i) % NUM_SOURCES);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        s_tready  = '0;
        fire      = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) state_nxt = PASS;
            end
            PASS: begin
                // A beat present on the saturating cycle wins over the timeout.
                fire               = WD_ENABLE && (wd_cnt == CNT_MAX) && !src_valid && out_free;
                s_tready[grantIdx] = out_free && !fire;
                accept             = src_valid && out_free;
                if (accept && src_last)
                    state_nxt = IDLE;
                else if (fire)
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                s_tready[grantIdx] = 1'b1;
                accept             = src_valid;
                if (accept && src_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            grantIdx      <= '0;
            rr_ptr        <= LAST_SRC;
            wd_cnt        <= '0;
            timeoutStrobe <= 1'b0;
            m_tvalid      <= 1'b0;
            m_tlast       <= 1'b0;
            m_tdata       <= '0;
            m_tuser       <= '0;
            m_tid         <= '0;
            m_terr        <= 1'b0;
        end else begin
            timeoutStrobe <= fire;

            if (state == IDLE && |req) grantIdx <= winner;
            if (state != IDLE && accept && src_last) rr_ptr <= grantIdx;

            // Downstream stalls never advance the watchdog: a valid source holds it.
            if (state != PASS || accept)
                wd_cnt <= '0;
            else if (WD_ENABLE && !src_valid && wd_cnt != CNT_MAX)
                wd_cnt <= wd_cnt + CNT_WIDTH'(1);

            if (state == PASS && accept) begin
                m_tvalid <= 1'b1;
                m_tlast  <= src_last;
                m_tdata  <= src_data;
                m_tuser  <= src_user;
                m_tid    <= grantIdx;
                m_terr   <= 1'b0;
            end else if (fire) begin
                m_tvalid <= 1'b1;
                m_tlast  <= 1'b1;
                m_tdata  <= '0;
                m_tuser  <= '0;
                m_tid    <= grantIdx;
                m_terr   <= 1'b1;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_arbiter.sv
`default_nettype none
// tb_axis_packet_arbiter : directed self-checking bench for axis_packet_arbiter.
module tb_axis_packet_arbiter;

    localparam int NS  = 4;
    localparam int DW  = 32;
    localparam int UW  = 1;
    localparam int IDW = 2;
    localparam int TO  = 16;

    logic                 clk = 1'b0;
    logic                 arst_n;
    logic                 mode;
    logic [NS-1:0]        enable;
    logic [NS-1:0]        s_tvalid;
    logic [NS-1:0]        s_tready;
    logic [NS-1:0]        s_tlast;
    logic [DW*NS-1:0]     s_tdata;
    logic [UW*NS-1:0]     s_tuser;
    logic                 m_tvalid;
    logic                 m_tready;
    logic                 m_tlast;
    logic [DW-1:0]        m_tdata;
    logic [UW-1:0]        m_tuser;
    logic [IDW-1:0]       m_tid;
    logic                 m_terr;
    logic                 timeoutStrobe;
    logic [IDW-1:0]       grantIdx;

    typedef struct packed {
        logic [IDW-1:0] tid;
        logic           err;
        logic           last;
        logic           user;
        logic [DW-1:0]  data;
    } beat_t;

    logic [DW:0]          srcq [NS][$];
    logic [DW:0]          expq [NS][$];
    beat_t                obs [$];
    logic [NS-1:0]        hs;
    logic                 rand_ready;
    logic                 stalled_prev;
    logic [DW+IDW+UW+2:0] prev_m;
    int                   checks   = 0;
    int                   failures = 0;
    int                   strobes  = 0;

    always #5 clk = ~clk;

    axis_packet_arbiter #(
        .NUM_SOURCES    (NS),
        .DATA_WIDTH     (DW),
        .USER_WIDTH     (UW),
        .ID_WIDTH       (IDW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .arst_n        (arst_n),
        .mode          (mode),
        .enable        (enable),
        .s_tvalid      (s_tvalid),
        .s_tready      (s_tready),
        .s_tlast       (s_tlast),
        .s_tdata       (s_tdata),
        .s_tuser       (s_tuser),
        .m_tvalid      (m_tvalid),
        .m_tready      (m_tready),
        .m_tlast       (m_tlast),
        .m_tdata       (m_tdata),
        .m_tuser       (m_tuser),
        .m_tid         (m_tid),
        .m_terr        (m_terr),
        .timeoutStrobe (timeoutStrobe),
        .grantIdx      (grantIdx)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic beat_t obs_at(input int k);
        return (k < obs.size()) ? obs[k] : '1;
    endfunction

    task automatic drive();
        logic [DW:0] b;
        for (int i = 0; i < NS; i++) begin
            b              = (srcq[i].size() > 0) ? srcq[i][0] : '0;
            s_tvalid[i]    = (srcq[i].size() > 0);
            s_tlast[i]     = b[DW];
            s_tdata[i*DW +: DW] = b[DW-1:0];
            s_tuser[i]     = b[0];
        end
    endtask

    task automatic push_pkt(input int src, input int len, input logic [DW-1:0] base);
        for (int b = 0; b < len; b++)
            srcq[src].push_back({(b == len - 1), base + DW'(b)});
    endtask

    // One bus cycle: retire last cycle's handshakes, drive, then sample.
    task automatic step();
        beat_t b;
        @(negedge clk);
        for (int i = 0; i < NS; i++)
            if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        drive();
        if (rand_ready) m_tready = ($urandom_range(0, 1) == 1);
        #1;
        hs = s_tvalid & s_tready;
        if (stalled_prev)
            check_eq("stable", {m_tvalid, m_tlast, m_terr, m_tid, m_tuser, m_tdata}, prev_m);
        stalled_prev = m_tvalid && !m_tready;
        prev_m       = {m_tvalid, m_tlast, m_terr, m_tid, m_tuser, m_tdata};
        if (m_tvalid && m_tready) begin
            b.tid  = m_tid;
            b.err  = m_terr;
            b.last = m_tlast;
            b.user = m_tuser[0];
            b.data = m_tdata;
            obs.push_back(b);
        end
        if (timeoutStrobe) strobes++;
    endtask

    task automatic run_until_obs(input int n, input int budget, input string tag);
        int cnt;
        cnt = 0;
        while (obs.size() < n && cnt < budget) begin
            step();
            cnt++;
        end
        check_eq(tag, obs.size(), n);
    endtask

    initial begin
        beat_t       b;
        int          gap;
        int          n;
        int          total;
        int          cnt [NS];
        logic [DW:0] e;

        arst_n = 1'b0; mode = 1'b0; enable = '1; m_tready = 1'b1;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tuser = '0;
        rand_ready = 1'b0; stalled_prev = 1'b0; hs = '0; prev_m = '0;
        repeat (3) @(negedge clk);
        arst_n = 1'b1;

        // Reset state
        step();
        check_eq("rst_m_tvalid", m_tvalid, 0);
        check_eq("rst_s_tready", s_tready, 0);
        check_eq("rst_grant", grantIdx, 0);
        check_eq("rst_m_out", {m_tlast, m_terr, m_tid, m_tdata, timeoutStrobe}, 0);

        // Latency: single-beat packet on source 3
        push_pkt(3, 1, 32'h0000_3333);
        step();
        check_eq("lat_n0_tready", s_tready, 4'b0000);
        step();
        check_eq("lat_n1_tready", s_tready, 4'b1000);
        check_eq("lat_n1_mvalid", m_tvalid, 0);
        step();
        check_eq("lat_n2_beat", {m_tvalid, m_tlast, m_terr, m_tid, m_tdata}, {1'b1, 1'b1, 1'b0, 2'd3, 32'h0000_3333});
        step();
        check_eq("lat_n3_mvalid", m_tvalid, 0);

        // Round robin, all sources valid, 2-beat packets
        obs.delete();
        for (int p = 0; p < 2; p++)
            for (int s = 0; s < NS; s++)
                push_pkt(s, 2, DW'((s << 12) | (p << 4)));
        run_until_obs(16, 200, "rr_count");
        for (int k = 0; k < 16; k++) begin
            b = obs_at(k);
            check_eq("rr_beat", {b.tid, b.err, b.last, b.user, b.data},
                     {IDW'((k / 2) % 4), 1'b0, (k % 2 == 1), (k % 2 == 1),
                      DW'((((k / 2) % 4) << 12) | ((k / 8) << 4) | (k % 2))});
        end

        // Fixed priority; source 0 disabled in the middle of its second packet
        obs.delete();
        mode = 1'b1;
        for (int p = 0; p < 3; p++) push_pkt(0, 3, DW'(32'h0A00 | (p << 4)));
        for (int p = 0; p < 2; p++) push_pkt(2, 3, DW'(32'h2A00 | (p << 4)));
        run_until_obs(4, 100, "pri_pre");
        enable = 4'b1110;
        run_until_obs(12, 100, "pri_count");
        repeat (6) step();
        check_eq("pri_extra", obs.size(), 12);
        for (int k = 0; k < 12; k++) begin
            b = obs_at(k);
            check_eq("pri_beat", {b.tid, b.last, b.data},
                     {(k < 6) ? 2'd0 : 2'd2, (k % 3 == 2),
                      DW'(((k < 6) ? 32'h0A00 : 32'h2A00) | (((k % 6) / 3) << 4) | (k % 3))});
        end
        srcq[0].delete();
        enable = '1;
        mode   = 1'b0;

        // Random backpressure, counting data per source
        obs.delete();
        total = 0;
        for (int s = 0; s < NS; s++) cnt[s] = 0;
        for (int s = 0; s < NS; s++)
            for (int p = 0; p < 4; p++) begin
                n = (s + p) % 3 + 1;
                for (int q = 0; q < n; q++) begin
                    e = {(q == n - 1), DW'((s << 12) | cnt[s])};
                    srcq[s].push_back(e);
                    expq[s].push_back(e);
                    cnt[s]++;
                    total++;
                end
            end
        rand_ready = 1'b1;
        run_until_obs(total, 3000, "bp_count");
        rand_ready = 1'b0;
        m_tready   = 1'b1;
        for (int k = 0; k < obs.size(); k++) begin
            b = obs[k];
            e = (expq[b.tid].size() > 0) ? expq[b.tid].pop_front() : '1;
            check_eq("bp_beat", {b.last, b.data}, e);
        end
        for (int s = 0; s < NS; s++) check_eq("bp_left", expq[s].size(), 0);

        // Watchdog: source 1 stalls mid-packet
        obs.delete();
        strobes = 0;
        srcq[1].push_back({1'b0, 32'h0000_AAAA});
        run_until_obs(1, 20, "wd_first");
        gap = 0;
        while (obs.size() < 2 && gap < 40) begin
            step();
            gap++;
        end
        check_eq("wd_gap", gap, 17);
        check_eq("wd_strobe_now", timeoutStrobe, 1);
        b = obs_at(0);
        check_eq("wd_beat0", {b.tid, b.err, b.last, b.data}, {2'd1, 1'b0, 1'b0, 32'h0000_AAAA});
        b = obs_at(1);
        check_eq("wd_term", {b.tid, b.err, b.last, b.user, b.data}, {2'd1, 1'b1, 1'b1, 1'b0, 32'h0});
        push_pkt(1, 3, 32'h0000_00B0);
        push_pkt(2, 1, 32'h0000_2222);
        push_pkt(0, 1, 32'h0000_1111);
        run_until_obs(4, 60, "wd_after");
        repeat (5) step();
        check_eq("wd_after_n", obs.size(), 4);
        b = obs_at(2);
        check_eq("wd_next_src2", {b.tid, b.err, b.data}, {2'd2, 1'b0, 32'h0000_2222});
        b = obs_at(3);
        check_eq("wd_then_src0", {b.tid, b.err, b.data}, {2'd0, 1'b0, 32'h0000_1111});
        check_eq("wd_strobes", strobes, 1);

        // Reset in the middle of a stalled packet
        obs.delete();
        m_tready = 1'b0;
        push_pkt(3, 5, 32'h0000_5500);
        n = 0;
        while (!m_tvalid && n < 20) begin
            step();
            n++;
        end
        check_eq("rst_pre_valid", m_tvalid, 1);
        #2;
        arst_n = 1'b0;
        #1;
        check_eq("rst_mid_mvalid", m_tvalid, 0);
        check_eq("rst_mid_tready", s_tready, 0);
        check_eq("rst_mid_grant", grantIdx, 0);
        for (int s = 0; s < NS; s++) srcq[s].delete();
        hs = '0;
        stalled_prev = 1'b0;
        m_tready = 1'b1;
        for (int s = 0; s < NS; s++) push_pkt(s, 1, DW'(32'h7700 | s));
        drive();
        @(negedge clk);
        arst_n = 1'b1;
        run_until_obs(1, 20, "rst_post");
        b = obs_at(0);
        check_eq("rst_post_first", {b.tid, b.data}, {2'd0, 32'h0000_7700});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
